uncached_dbridge: RTL and testbench
===================================

Name: uncached_dbridge

Overview:
- Responder on the CPU-side DCache request interface (d_addr/d_en/w_b_s/d_wdata/d_size/cached_DCache) for uncached accesses only (cached_DCache=0, i.e. the kseg1 window after translation).
- Converts each uncached load/store into a single-beat bus transaction (AR/R or AW/W/B) and holds the CPU with u_stall until the transaction completes.
- Cached requests are ignored here; they are serviced by the DCache.
- Sits between the address translator and the system bus arbiter.

Parameters:
WAIT_LIMIT, 1024, max cycles in any bus-wait state before forced error completion; 0 disables the timeout.
ERR_DATA, 32'hDEAD_BEEF, u_rdata value returned on timeout.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
d_addr  in  32  physical address
d_en  in  2  bit0 = request valid; bit1 = 1 write / 0 read
w_b_s  in  4  byte strobes for writes
d_wdata  in  32  write data, already lane-aligned
d_size  in  3  0 byte, 1 half, 2 word; others reserved
cached_DCache  in  1  0 = request is for this block
u_rdata  out  32  read data, raw bus word, no lane shifting
u_stall  out  1  hold CPU
u_err  out  1  one-cycle pulse on timeout completion
araddr  out  32  read address
arsize  out  3  = captured d_size
arvalid  out  1  read address valid
arready  in  1  read address accepted
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data accept
awaddr  out  32  write address
awsize  out  3  = captured d_size
awvalid  out  1  write address valid
awready  in  1  write address accepted
wdata  out  32  write data
wstrb  out  4  = captured w_b_s
wvalid  out  1  write data valid
wready  in  1  write data accepted
bvalid  in  1  write response valid
bready  out  1  write response accept

Behaviour:
- Reset values: state IDLE; all valid/ready outputs 0; u_stall 0; u_err 0; u_rdata 0; captured address/data/strb/size 0; timeout counter 0.
- A request is "hit" when d_en[0]=1 and cached_DCache=0.
- IDLE:
  - u_stall = hit (combinational, same cycle).
  - On hit, capture d_addr, d_wdata, w_b_s, d_size; go to RD_ADDR (d_en[1]=0) or WR_REQ (d_en[1]=1).
- RD_ADDR:
  - arvalid=1, u_stall=1.
  - On arvalid&arready go to RD_DATA.
  - araddr and arsize stay stable while arvalid=1.
- RD_DATA:
  - rready=1, u_stall=1.
  - On rvalid, latch rdata into u_rdata and go to DONE.
- WR_REQ:
  - awvalid and wvalid both assert on entry; each drops independently after its own handshake. AW and W may complete in either order or in the same cycle.
  - u_stall=1.
  - Once both handshakes have completed, go to WR_RESP.
- WR_RESP:
  - bready=1, u_stall=1.
  - On bvalid go to DONE. u_rdata is unchanged on writes.
- DONE:
  - u_stall=0 for exactly one cycle. The CPU advances on this edge and the current request is consumed, not re-sampled.
  - Unconditionally return to IDLE. A new hit is evaluated only in IDLE.
- Minimum latency is 3 stall cycles. Read with arready and rvalid both immediate: IDLE(stall) -> RD_ADDR -> RD_DATA -> DONE(no stall).
- Timeout:
  - The counter clears on every state change.
  - It increments each cycle spent in RD_ADDR, RD_DATA, WR_REQ or WR_RESP.
  - When the counter reaches WAIT_LIMIT-1 without completion:
    - deassert all valid/ready outputs;
    - read: set u_rdata=ERR_DATA;
    - pulse u_err in the DONE cycle;
    - go to DONE.
  - Late bus responses are then ignored because rready/bready are 0.
- Cached requests (cached_DCache=1) never leave IDLE and never raise u_stall.
- d_en changes while busy: ignored; captured values are used.
- Reset mid-transaction: return to IDLE next edge with all outputs at reset values. Any in-flight bus transaction is abandoned and its response is not accepted.
- d_size values 3..7: forwarded unchanged on arsize/awsize; no checking.

Test Plan:
- Uncached read, d_addr=0x1FC0_0010, d_size=2, arready=1, rvalid returned 1 cycle after AR with rdata=0x1234_5678 -> araddr=0x1FC0_0010, arsize=2, u_stall high exactly 3 cycles, u_rdata=0x1234_5678 in the DONE cycle.
- Byte write, d_addr=0x1FAF_0003, w_b_s=4'b1000, d_wdata=0xAB00_0000, wready 2 cycles before awready, bvalid 3 cycles later -> each channel handshakes once, wstrb=4'b1000, wdata=0xAB00_0000, u_stall drops only after B, u_rdata unchanged.
- Cached request, d_en=2'b01, cached_DCache=1, for 10 cycles -> no valid outputs, u_stall=0 throughout.
- Timeout with WAIT_LIMIT=8 and arready held 0 -> DONE after 8 cycles in RD_ADDR, u_rdata=0xDEAD_BEEF, u_err pulses 1 cycle, a later rvalid is not accepted.
- Back-to-back reads with d_en held high across DONE -> exactly two AR transactions, one IDLE stall cycle between them.
- Reset asserted during WR_RESP -> next cycle all outputs at reset values, bready=0, u_stall=0; a subsequent read completes normally.

Source files
------------

// File: rtl/uncached_dbridge.sv
// Uncached DCache-side bridge: turns one uncached CPU load/store into a single-beat
// AR/R or AW/W/B bus transaction and stalls the CPU until it completes or times out.
module uncached_dbridge #(
    parameter int unsigned WAIT_LIMIT = 1024,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_en,
    input  logic [3:0]  w_b_s,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    input  logic        cached_DCache,
    output logic [31:0] u_rdata,
    output logic        u_stall,
    output logic        u_err,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
    } state_t;

    localparam int unsigned CW      = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_LIMIT - 1);
    localparam bit          TO_EN   = (WAIT_LIMIT != 0);

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    strb_q, strb_d;
    logic [2:0]    size_q, size_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic hit, waiting, timeout, to_fire;
    logic ar_hs, aw_hs, w_hs, wr_req_done;

    assign hit         = d_en[0] & ~cached_DCache;
    assign waiting     = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                         (state_q == WR_REQ)  || (state_q == WR_RESP);
    assign timeout     = TO_EN && waiting && (cnt_q == CNT_MAX);
    assign ar_hs       = arvalid & arready;
    assign aw_hs       = awvalid & awready;
    assign w_hs        = wvalid & wready;
    assign wr_req_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A handshake in the final wait cycle still wins over the timeout.
    always_comb begin
        state_d = state_q;
        to_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) state_d = d_en[1] ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                if (ar_hs)        state_d = RD_DATA;
                else if (timeout) begin state_d = DONE; to_fire = 1'b1; end
            end
            RD_DATA: begin
                if (rvalid)       state_d = DONE;
                else if (timeout) begin state_d = DONE; to_fire = 1'b1; end
            end
            WR_REQ: begin
                if (wr_req_done)  state_d = WR_RESP;
                else if (timeout) begin state_d = DONE; to_fire = 1'b1; end
            end
            WR_RESP: begin
                if (bvalid)       state_d = DONE;
                else if (timeout) begin state_d = DONE; to_fire = 1'b1; end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && hit) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            strb_d  = w_b_s;
            size_d  = d_size;
        end
        if (state_q == RD_DATA && rvalid) begin
            rdata_d = rdata;
        end else if (to_fire && (state_q == RD_ADDR || state_q == RD_DATA)) begin
            rdata_d = ERR_DATA;
        end
        aw_done_d = (state_d == WR_REQ) & (aw_done_q | aw_hs);
        w_done_d  = (state_d == WR_REQ) & (w_done_q | w_hs);
        cnt_d     = (TO_EN && waiting && state_d == state_q) ? cnt_q + 1'b1 : '0;
        err_d     = to_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            size_q    <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            size_q    <= size_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        u_stall = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (state_q)
            IDLE:    u_stall = hit;
            RD_ADDR: begin u_stall = 1'b1; arvalid = 1'b1; end
            RD_DATA: begin u_stall = 1'b1; rready = 1'b1; end
            WR_REQ: begin
                u_stall = 1'b1;
                awvalid = ~aw_done_q;
                wvalid  = ~w_done_q;
            end
            WR_RESP: begin u_stall = 1'b1; bready = 1'b1; end
            default: u_stall = 1'b0;
        endcase
    end

    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign arsize  = size_q;
    assign awsize  = size_q;
    assign wdata   = wdata_q;
    assign wstrb   = strb_q;
    assign u_rdata = rdata_q;
    assign u_err   = err_q;

endmodule

// File: tb/tb_uncached_dbridge.sv
// Self-checking bench for uncached_dbridge: directed scenarios plus randomized
// transactions with random bus latencies, checked against a latency/result model.
module tb_uncached_dbridge;

    localparam int          LIMIT = 8;
    localparam logic [31:0] ERR   = 32'hDEAD_BEEF;
    localparam int          NEVER = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_addr;
    logic [1:0]  d_en;
    logic [3:0]  w_b_s;
    logic [31:0] d_wdata;
    logic [2:0]  d_size;
    logic        cached_DCache;
    logic [31:0] u_rdata;
    logic        u_stall, u_err;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int          numCompared = 0;
    int          numMismatched = 0;
    logic [31:0] modelRdata = '0;

    uncached_dbridge #(.WAIT_LIMIT(LIMIT), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .d_addr(d_addr), .d_en(d_en), .w_b_s(w_b_s), .d_wdata(d_wdata), .d_size(d_size),
        .cached_DCache(cached_DCache),
        .u_rdata(u_rdata), .u_stall(u_stall), .u_err(u_err),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctrlVec();
        return {arvalid, rready, awvalid, wvalid, bready, u_stall, u_err};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        numCompared++;
        if (obs !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rstCtrl", 64'(ctrlVec()), 64'(0));
        checkOutput("rstRdata", 64'(u_rdata), 64'(0));
        checkOutput("rstAddr", {araddr, awaddr}, 64'(0));
        checkOutput("rstData", 64'({wdata, wstrb, arsize, awsize}), 64'(0));
    endtask

    // aLat/wLat/respLat: cycles the valid (or ready) waits before the bus answers.
    task automatic applyStimulus(input bit isWr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [2:0] size,
                                 input int aLat, input int wLat, input int respLat, input bit keepEn);
        int aCnt = 0, wCnt = 0, rCnt = 0, aHs = 0, wHs = 0, respHs = 0;
        int stalls = 0, badField = 0, wrongCh = 0, m, reqCycles, expStall;
        bit reqTo, expTo, done = 0;
        logic [31:0] newRdata;
        m         = (aLat > wLat) ? aLat : wLat;
        reqTo     = isWr ? (m >= LIMIT) : (aLat >= LIMIT);
        expTo     = reqTo || (respLat >= LIMIT);
        reqCycles = reqTo ? LIMIT : ((isWr ? m : aLat) + 1);
        expStall  = 1 + reqCycles + (reqTo ? 0 : ((respLat >= LIMIT) ? LIMIT : respLat + 1));
        newRdata  = isWr ? modelRdata : (expTo ? ERR : data);
        @(negedge clk);
        d_addr = addr; d_en = {isWr, 1'b1}; cached_DCache = 1'b0;
        w_b_s = strb; d_size = size; d_wdata = isWr ? data : $urandom();
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            arready = arvalid && (aCnt == aLat);
            awready = awvalid && (aCnt == aLat);
            wready  = wvalid && (wCnt == wLat);
            rvalid  = rready && (rCnt == respLat);
            bvalid  = bready && (rCnt == respLat);
            rdata   = rvalid ? data : $urandom();
            #1;
            if (cyc == 0) checkOutput("idleStall", 64'({u_stall, arvalid | awvalid | wvalid}), 64'(2'b10));
            if (isWr ? (arvalid | rready) : (awvalid | wvalid | bready)) wrongCh++;
            if (u_err && u_stall) wrongCh++;
            if (arvalid | awvalid) begin
                if ((isWr ? awaddr : araddr) !== addr || (isWr ? awsize : arsize) !== size) badField++;
                if (arready | awready) aHs++; else aCnt++;
            end
            if (wvalid) begin
                if (wdata !== data || wstrb !== strb) badField++;
                if (wready) wHs++; else wCnt++;
            end
            if (rready | bready) begin
                if (rvalid | bvalid) respHs++; else rCnt++;
            end
            if (u_stall) begin
                stalls++;
            end else begin
                done = 1;
                checkOutput("doneRdata", 64'(u_rdata), 64'(newRdata));
                checkOutput("doneErr", 64'(u_err), 64'(expTo));
                if (!keepEn) d_en = 2'b00;
            end
        end
        if (!done) checkOutput("doneReached", 64'(0), 64'(1));
        modelRdata = newRdata;
        checkOutput("stallCycles", 64'(stalls), 64'(expStall));
        checkOutput("addrHandshakes", 64'(aHs), 64'(aLat < LIMIT));
        checkOutput("wHandshakes", 64'(wHs), 64'(isWr && wLat < LIMIT));
        checkOutput("respHandshakes", 64'(respHs), 64'(!reqTo && respLat < LIMIT));
        checkOutput("fieldsStable", 64'(badField), 64'(0));
        checkOutput("wrongChannel", 64'(wrongCh), 64'(0));
    endtask

    function automatic int randLat();
        return ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 5));
    endfunction

    initial begin
        rst = 1'b1; d_addr = '0; d_en = '0; w_b_s = '0; d_wdata = '0; d_size = '0;
        cached_DCache = 1'b0; arready = 0; rvalid = 0; rdata = '0; awready = 0; wready = 0; bvalid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetState();
        rst = 1'b0;

        applyStimulus(1'b0, 32'h1FC0_0010, 32'h1234_5678, 4'hF, 3'd2, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 32'h1FAF_0003, 32'hAB00_0000, 4'b1000, 3'd0, 2, 0, 3, 1'b0);

        // Cached requests must be invisible to the bus and never stall.
        @(negedge clk);
        d_en = 2'b01; cached_DCache = 1'b1; d_addr = 32'h8000_0040;
        for (int i = 0; i < 10; i++) begin
            #1 checkOutput("cachedIgnored", 64'(ctrlVec()), 64'(0));
            @(negedge clk);
        end
        d_en = 2'b00; cached_DCache = 1'b0;

        // Timeout on AR, then a late R beat must not be accepted.
        applyStimulus(1'b0, 32'h1FC0_0100, 32'h0BAD_0BAD, 4'hF, 3'd2, NEVER, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rvalid = 1'b1; rdata = 32'h5555_AAAA;
            #1;
            checkOutput("lateRready", 64'(rready), 64'(0));
            checkOutput("lateRdata", 64'(u_rdata), 64'(ERR));
            checkOutput("errOneCycle", 64'(u_err), 64'(0));
        end
        rvalid = 1'b0;

        applyStimulus(1'b0, 32'h1FC0_0200, 32'hCAFE_0001, 4'hF, 3'd2, 0, 0, 0, 1'b1);
        applyStimulus(1'b0, 32'h1FC0_0204, 32'hCAFE_0002, 4'hF, 3'd2, 1, 0, 1, 1'b0);

        // Reset while waiting for the write response.
        @(negedge clk);
        d_addr = 32'h1F00_0010; d_en = 2'b11; d_wdata = 32'h0102_0304; w_b_s = 4'hF; d_size = 3'd2;
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 checkOutput("wrRespReached", 64'({bready, u_stall}), 64'(2'b11));
        rst = 1'b1; d_en = 2'b00; awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        #1 checkResetState();
        rst = 1'b0;
        modelRdata = '0;
        applyStimulus(1'b0, 32'h1FC0_0300, 32'h7777_0000, 4'hF, 3'd2, 0, 0, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)), randLat(), randLat(), randLat(),
                          1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
